// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage responder between the EXE/MEM and MEM/WB
// registers. Services one load/store at a time against an internal
// word-organised data memory with a fixed number of wait states, holding
// the pipeline frozen (ready=0) while an access is in flight.
//
// Parameters:
//   DEPTH       data memory size in 32-bit words (power of two)
//   BASE_ADDR   byte address mapped to word 0
//   WAIT_STATES busy cycles inserted per access (0..15)
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   mem_r_en load request (held while ready=0)
//   mem_w_en store request (held while ready=0); wins over mem_r_en
//   address  byte address from the ALU
//   wr_data  store data
//   rd_data  registered load data, valid from the cycle after DONE
//   ready    combinational stall release: (IDLE & !req) | DONE
//   err      registered misalignment flag
//
// Optional feature: define MEM_ALIGN_CHECK_EN to reject accesses whose
// address[1:0] is non-zero (no wait states, no side effects, err=1).
// Without it the low address bits are ignored and err stays 0.
module mem_access_unit #(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned WAIT_STATES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  input  logic [31:0] address,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        ready,
  output logic        err
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = 4;
  localparam bit          HAS_WAIT = (WAIT_STATES != 0);
  localparam logic [CNT_W-1:0] CNT_INIT =
    HAS_WAIT ? CNT_W'(WAIT_STATES - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        rd_data_q, rd_data_d;
  logic               err_q, err_d;
  logic [31:0]        mem_q [DEPTH];

  logic               req_c;
  logic               misalign_c;
  logic               in_range_c;
  logic               store_c;
  logic [31:0]        word_off_c;
  logic [IDX_W-1:0]   idx_c;

  // Address decode; addresses below BASE_ADDR wrap to a huge offset.
  assign req_c      = mem_r_en | mem_w_en;
  assign word_off_c = (address - 32'(BASE_ADDR)) >> 2;
  assign in_range_c = (word_off_c < 32'(DEPTH));
  assign idx_c      = word_off_c[IDX_W-1:0];

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign_c = |address[1:0];
`else
  assign misalign_c = 1'b0;
`endif

  // State, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rd_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_data_q <= rd_data_d;
      err_q     <= err_d;
    end
  end

  // Data memory is not reset; a reset edge suppresses a pending store.
  always_ff @(posedge clk) begin
    if (!rst && store_c) begin
      mem_q[idx_c] <= wr_data;
    end
  end

  // Next-state, commit decisions and ready.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_data_d = rd_data_q;
    err_d     = err_q;
    store_c   = 1'b0;
    ready     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        ready = !req_c;
        if (req_c) begin
          if (misalign_c || !HAS_WAIT) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_BUSY;
            cnt_d   = CNT_INIT;
          end
        end
      end
      ST_BUSY: begin
        if (cnt_q == '0) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        ready   = 1'b1;
        state_d = ST_IDLE;
        err_d   = misalign_c;
        // Inputs are still held here, so the commit uses them directly.
        if (!misalign_c) begin
          if (mem_w_en) begin
            store_c = in_range_c;
          end else if (mem_r_en) begin
            rd_data_d = in_range_c ? mem_q[idx_c] : '0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign rd_data = rd_data_q;
  assign err     = err_q;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage responder for the ARM pipeline: consumes the load/store requests the execute stage produces (read/write enables, ALU-computed address, store data taken from the forwarded Rm value) and services them against an internal word-organised data memory with a fixed, parameterised number of wait states. It sits between the EXE/MEM pipeline register and the MEM/WB register. It drives `ready` low to freeze the pipeline while an access is in flight, and returns load data to write-back.

## Interface
- `DEPTH`, 64: data memory size in 32-bit words; power of two.
- `BASE_ADDR`, 1024: byte address mapped to word 0.
- `WAIT_STATES`, 3: busy cycles inserted per access; legal range 0..15.
- `clk`  in  1  rising-edge clock for all state.
- `rst`  in  1  synchronous, active-high reset.
- `mem_r_en`  in  1  load request, held stable by the pipeline while `ready`=0.
- `mem_w_en`  in  1  store request, held stable while `ready`=0.
- `address`  in  32  byte address (ALU result).
- `wr_data`  in  32  store data (selected Rm value).
- `rd_data`  out  32  load data, registered.
- `ready`  out  1  0 = freeze pipeline; 1 = stage may advance.
- `err`  out  1  registered; only driven non-zero with `MEM_ALIGN_CHECK_EN`.

## Operation
- Word index = (`address` − `BASE_ADDR`) >> 2, computed in 32-bit unsigned arithmetic. The access is in range iff index < `DEPTH`. An address below `BASE_ADDR` wraps to a huge index and is therefore out of range.
- `req` = `mem_r_en` | `mem_w_en`. If both enables are set, the access is treated as a store. `rd_data` is unchanged.
- FSM states and transitions:
  - IDLE → BUSY on `req` when `WAIT_STATES`>0; the wait counter loads `WAIT_STATES`−1.
  - IDLE → DONE on `req` when `WAIT_STATES`=0.
  - BUSY: the counter decrements each cycle. BUSY → DONE when the counter = 0.
  - DONE → IDLE unconditionally.
- Commit on the clock edge that leaves DONE:
  - In-range store: writes `wr_data` to the memory word.
  - In-range load: registers the word into `rd_data`.
  - Out-of-range store: dropped.
  - Out-of-range load: `rd_data` ← 0.
- `ready` (combinational) = (IDLE & !`req`) | DONE.
- Requests are sampled only in IDLE. Input changes during BUSY/DONE violate the protocol and need not be handled.
- Reset:
  - State ← IDLE, counter ← 0, `rd_data` ← 0, `err` ← 0.
  - Memory array is not reset.
  - Reset during BUSY/DONE aborts the access: no store is committed and `rd_data` is not updated.

## Timing
- `ready` falls in the same cycle a request appears in IDLE. It stays low for `WAIT_STATES`+1 cycles (the request cycle plus the BUSY cycles), then is high for exactly one DONE cycle.
- Total request-to-release: `WAIT_STATES`+2 cycles, counting the DONE cycle.
- `rd_data` is valid from the cycle after DONE onward, aligned with the MEM/WB register capture. It holds until the next load commits.
- Back-to-back requests: the cycle after DONE is IDLE. A new request there drops `ready` immediately, so no request is lost.
- A store's new value is visible to a load issued on the next request.

## Configuration
- Macro: `MEM_ALIGN_CHECK_EN`.
- Defined:
  - A request with `address[1:0]`≠0 takes IDLE → DONE with no wait states.
  - No memory write occurs and `rd_data` is unchanged.
  - `err` is set to 1 on the edge leaving DONE and held until the next completed access clears it, or reset.
- Undefined: `address[1:0]` is ignored (access truncates to the word) and `err` is tied to 0.

## Test plan
- `WAIT_STATES`=3. Store 0xDEADBEEF to 1024, then load 1024:
  - `ready` is low for 4 cycles and high for 1 on each access.
  - After the load, `rd_data`=0xDEADBEEF.
- `WAIT_STATES`=0. Store 0x12345678 to 1028, then load 1028 back-to-back:
  - `ready` is low for 1 cycle per access.
  - `rd_data`=0x12345678; word at 1024 unchanged.
- Out of range:
  - Store 0xFFFFFFFF to 1024+4·`DEPTH`, then load the same address → `rd_data`=0, all in-range words unchanged.
  - Load address 0 → `rd_data`=0.
- Assert `rst` during the second BUSY cycle of a store of 0xAAAA5555 to 1032:
  - FSM returns to IDLE, `ready`=1, `rd_data`=0.
  - A subsequent load of 1032 returns the prior contents.
- Both enables set, address 1036, `wr_data`=0xCAFEF00D:
  - Word is written.
  - `rd_data` keeps its previous value.
- With `MEM_ALIGN_CHECK_EN`, store to 1026:
  - `ready` is low 1 cycle.
  - `err`=1 after DONE; word 1024 unchanged.
  - The next aligned access clears `err`.
